shift_sequencer: RTL
====================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have port CLK, input, 1, sole clock; all state changes on its rising edge.
REQ-002 SHALL have port RST_N, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port CMD_VALID, input, 1, command offered.
REQ-004 SHALL have port CMD_READY, output, 1, command accepted when high together with CMD_VALID at a rising edge.
REQ-005 SHALL have port CMD_DATA, input, 4, word to load into the shift register.
REQ-006 SHALL have port CMD_DIR, input, 1, shift direction: 0 = toward bit 3 (fill enters bit 0), 1 = toward bit 0 (fill enters bit 3).
REQ-007 SHALL have port CMD_COUNT, input, 3, number of shifts, 0..7.
REQ-008 SHALL have port CMD_FILL, input, 1, serial fill bit.
REQ-009 SHALL have port Q, input, 4, feedback from the downstream shift register output O.
REQ-010 SHALL have ports LOAD, output, 1; LR_Shift, output, 1; D, output, 4; together these drive the downstream shift register.
REQ-011 SHALL have port BUSY, output, 1, high in any state other than IDLE.
REQ-012 SHALL have port DONE, output, 1, one-cycle completion pulse.
REQ-013 SHALL have port RESULT, output, 4, register contents captured at completion.

Function
REQ-014 SHALL implement the FSM states IDLE, LOAD, SHIFT and CAPTURE.
REQ-015 IDLE: CMD_READY=1, LOAD=1, D=Q, LR_Shift=0; this hold-by-reload keeps the downstream register contents stable, since that register shifts whenever LOAD=0.
REQ-016 IDLE->LOAD on CMD_VALID&CMD_READY; SHALL latch CMD_DATA, CMD_DIR, CMD_COUNT and CMD_FILL at that edge.
REQ-017 LOAD (exactly 1 cycle): LOAD=1, D=latched data; SHALL go to SHIFT if count>0, else to CAPTURE.
REQ-018 SHIFT (exactly count cycles): LOAD=0, LR_Shift=latched dir, D={4{fill_bit}}; SHALL use a 3-bit down-counter and go to CAPTURE after the final shift cycle.
REQ-019 CAPTURE (1 cycle): LOAD=1, D=Q, LR_Shift=0; at the exiting edge SHALL set RESULT<=Q and DONE<=1, then go to IDLE.
REQ-020 DONE SHALL be high for exactly the one cycle after CAPTURE; a new command MAY be accepted in that same cycle (back-to-back).
REQ-021 Latency: accept at edge k -> DONE high and RESULT valid after edge k+2+count.
REQ-022 CMD_VALID while not IDLE SHALL be ignored; CMD_* SHALL NOT affect an operation in flight.
REQ-023 LOAD, LR_Shift and D SHALL be combinational from state, latched command and Q only; no path from CMD_* inputs.

Reset
REQ-024 RST_N low SHALL force immediately: state=IDLE, counter=0, RESULT=4'b0000, DONE=0, CMD_READY=0, BUSY=0.
REQ-025 CMD_READY SHALL remain 0 until the first rising edge after RST_N deasserts.
REQ-026 Reset mid-operation SHALL abort the operation with no DONE pulse and RESULT=0.

Configuration
REQ-027 Macro SHIFT_SEQ_ROTATE_EN: when defined, fill_bit SHALL be Q[3] for dir=0 and Q[0] for dir=1 (rotate), and CMD_FILL SHALL be ignored.
REQ-028 When the macro is undefined, fill_bit SHALL be the latched CMD_FILL.

Verification
REQ-029 DATA=1011, DIR=0, COUNT=1, FILL=0 -> RESULT=0110, DONE 3 cycles after accept.
REQ-030 DATA=1011, DIR=0, COUNT=2, FILL=1 -> RESULT=1111; DATA=1011, DIR=1, COUNT=1, FILL=0 -> RESULT=0101.
REQ-031 COUNT=0, DATA=1001 -> RESULT=1001, DONE 2 cycles after accept; register held at 1001 through 10 further idle cycles.
REQ-032 ROTATE_EN defined: DATA=1011, DIR=0, COUNT=4 -> RESULT=1011; COUNT=1 -> RESULT=0111.
REQ-033 RST_N pulsed low during SHIFT -> no DONE, RESULT=0000, CMD_READY=0 during reset and 1 from the first edge after release.
REQ-034 Second command held on CMD_VALID during BUSY -> accepted in the DONE cycle, first RESULT unaffected.

Source files
------------

// File: rtl/shift_sequencer.sv
// shift_sequencer: command-driven sequencer for a downstream 4-bit
// load/shift register. It loads a word, applies 0..7 single-bit shifts
// with a serial fill, then captures the register output into RESULT.
// The downstream register shifts whenever LOAD is low, so every
// non-shifting state drives LOAD=1 with D=Q to hold its contents.
//
// Build option: define SHIFT_SEQ_ROTATE_EN to make the fill bit come
// from the register's own outgoing bit (rotate) instead of CMD_FILL.
module shift_sequencer (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [3:0] CMD_DATA,
  input  logic       CMD_DIR,
  input  logic [2:0] CMD_COUNT,
  input  logic       CMD_FILL,
  input  logic [3:0] Q,
  output logic       LOAD,
  output logic       LR_Shift,
  output logic [3:0] D,
  output logic       BUSY,
  output logic       DONE,
  output logic [3:0] RESULT
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_CAPT  = 2'd3;

  logic [1:0] state_q, state_d;
  logic [3:0] data_q,  data_d;
  logic       dir_q,   dir_d;
  logic [2:0] cnt_q,   cnt_d;
  logic [3:0] result_q, result_d;
  logic       done_q,  done_d;
  logic       armed_q;
  logic       fill_bit;
  logic       accept;

`ifdef SHIFT_SEQ_ROTATE_EN
  // Rotate: the bit leaving the register re-enters at the other end.
  logic unused_fill;
  assign unused_fill = CMD_FILL;
  assign fill_bit    = dir_q ? Q[0] : Q[3];
`else
  logic fill_q, fill_d;
  assign fill_bit = fill_q;
`endif

  // Ready only once out of reset for at least one edge, and only in IDLE.
  assign CMD_READY = armed_q && (state_q == S_IDLE);
  assign accept    = CMD_VALID && CMD_READY;
  assign BUSY      = (state_q != S_IDLE);
  assign DONE      = done_q;
  assign RESULT    = result_q;

  // Downstream register controls; no path from the CMD_* inputs.
  always_comb begin
    LOAD     = 1'b1;
    LR_Shift = 1'b0;
    D        = Q;
    case (state_q)
      S_LOAD:  D = data_q;
      S_SHIFT: begin
        LOAD     = 1'b0;
        LR_Shift = dir_q;
        D        = {4{fill_bit}};
      end
      default: D = Q;
    endcase
  end

  // Next-state and command latch logic.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
`ifndef SHIFT_SEQ_ROTATE_EN
    fill_d   = fill_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          data_d  = CMD_DATA;
          dir_d   = CMD_DIR;
          cnt_d   = CMD_COUNT;
`ifndef SHIFT_SEQ_ROTATE_EN
          fill_d  = CMD_FILL;
`endif
          state_d = S_LOAD;
        end
      end
      S_LOAD: state_d = (cnt_q != 3'd0) ? S_SHIFT : S_CAPT;
      S_SHIFT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = S_CAPT;
      end
      default: begin
        result_d = Q;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any operation and clears RESULT.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      data_q   <= 4'd0;
      dir_q    <= 1'b0;
      cnt_q    <= 3'd0;
      result_q <= 4'd0;
      done_q   <= 1'b0;
      armed_q  <= 1'b0;
`ifndef SHIFT_SEQ_ROTATE_EN
      fill_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
      armed_q  <= 1'b1;
`ifndef SHIFT_SEQ_ROTATE_EN
      fill_q   <= fill_d;
`endif
    end
  end

endmodule
